regfile_dump: RTL and testbench

Sequential reader that sweeps a contiguous, wrap-around range of register-file entries through one asynchronous read port and streams each entry out over a valid/ready interface. It sits beside the 32 x 64-bit register file as its debug/trace consumer: it drives the read address, captures the read data, and hands `{addr, data}` beats to a downstream sink (UART framer, trace buffer, testbench monitor). It never writes the register file.

---
 rtl/regfile_dump_if.sv | 29 ++
 rtl/regfile_dump.sv | 94 +++++++++
 tb/tb_regfile_dump.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Handshake and register-file read bundle between regfile_dump and its environment.
// master = the dump engine; slave = register file plus downstream sink / start requester.
interface regfile_dump_if #(
  parameter int N  = 64,
  parameter int AW = 5
);
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] ra;
  logic [N-1:0]  rd;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  modport master (
    input  start, first_addr, last_addr, rd, out_ready,
    output ra, out_valid, out_data, out_addr, out_last, busy, done
  );

  modport slave (
    output start, first_addr, last_addr, rd, out_ready,
    input  ra, out_valid, out_data, out_addr, out_last, busy, done
  );
endinterface

// File: rtl/regfile_dump.sv
// Sweeps a wrap-around register range through one async read port, streaming {addr,data} beats.
// Two cycles per beat (LOAD then SEND); a beat holds stable in SEND until out_ready.
module regfile_dump #(
  parameter int N  = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  regfile_dump_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_cur;
  logic [AW-1:0] r_end;
  logic [N-1:0]  r_data;
  logic [AW-1:0] r_addr;
  logic          r_last;
  logic          w_valid;
  logic          w_busy;
  logic          w_done;
  logic          w_hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    w_hs    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: w_next = S_SEND;
      S_SEND: begin
        w_valid = 1'b1;
        w_hs    = bus.out_ready;
        if (bus.out_ready) w_next = r_last ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Beat registers are captured only in LOAD, so later writes to the entry do not leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur  <= '0;
      r_end  <= '0;
      r_data <= '0;
      r_addr <= '0;
      r_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cur <= bus.first_addr;
            r_end <= bus.last_addr;
          end
        end
        S_LOAD: begin
          r_data <= bus.rd;
          r_addr <= r_cur;
          r_last <= (r_cur == r_end);
        end
        S_SEND: begin
          if (w_hs && !r_last) r_cur <= r_cur + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ra        = r_cur;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = r_data;
  assign bus.out_addr  = r_addr;
  assign bus.out_last  = r_last;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural 32 x 64 register file on the read port.
module tb_regfile_dump;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] regs [32];
  logic [4:0]  q_addr [$];
  logic [63:0] q_data [$];
  bit          q_last [$];

  regfile_dump_if #(.N(64), .AW(5)) bus ();

  regfile_dump #(.N(64), .AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.rd = (bus.ra == 5'd31) ? 64'd0 : regs[bus.ra];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic kick(input logic [4:0] f, input logic [4:0] l);
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.first_addr = f;
    bus.last_addr  = l;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Records handshaken beats; cycle 1 is the LOAD cycle after the accepting edge.
  task automatic collect(input int budget, output int done_cyc);
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    done_cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        q_addr.push_back(bus.out_addr);
        q_data.push_back(bus.out_data);
        q_last.push_back(bus.out_last);
      end
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b busy=%b done=%b last=%b, want all 0",
               bus.out_valid, bus.busy, bus.done, bus.out_last);
    end
    checks++;
    if (bus.out_data !== 64'd0 || bus.out_addr !== 5'd0 || bus.ra !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: data=%h addr=%0d ra=%0d, want 0/0/0", bus.out_data, bus.out_addr, bus.ra);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, want 0/0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_single;
    bus.out_ready = 1'b1;
    kick(5'd5, 5'd5);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_load: valid=%b busy=%b, want 0/1", bus.out_valid, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_addr !== 5'd5 || bus.out_data !== 64'd5 || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL single_beat: valid=%b addr=%0d data=%h last=%b, want 1/5/5/1",
               bus.out_valid, bus.out_addr, bus.out_data, bus.out_last);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done: done=%b valid=%b busy=%b, want 1/0/1", bus.done, bus.out_valid, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b done=%b, want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_full_sweep;
    int dc;
    bus.out_ready = 1'b1;
    kick(5'd0, 5'd31);
    collect(80, dc);
    checks++;
    if (q_addr.size() != 32) begin
      errors++;
      $display("FAIL sweep_count: got %0d beats, want 32", q_addr.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (q_addr[i] !== 5'(i) || q_data[i] !== ((i == 31) ? 64'd0 : 64'(i)) || q_last[i] !== (i == 31)) begin
          errors++;
          $display("FAIL sweep_beat%0d: addr=%0d data=%h last=%b", i, q_addr[i], q_data[i], q_last[i]);
        end
      end
    end
    checks++;
    if (dc != 65) begin
      errors++;
      $display("FAIL sweep_timing: done in cycle %0d, want 65", dc);
    end
  endtask

  task automatic test_wrap;
    int          dc;
    logic [4:0]  ea [4];
    logic [63:0] ed [4];
    ea = '{5'd30, 5'd31, 5'd0, 5'd1};
    ed = '{64'd30, 64'd0, 64'd0, 64'd1};
    kick(5'd30, 5'd1);
    collect(20, dc);
    checks++;
    if (q_addr.size() != 4 || dc != 9) begin
      errors++;
      $display("FAIL wrap_count: got %0d beats done cycle %0d, want 4 and 9", q_addr.size(), dc);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_addr[i] !== ea[i] || q_data[i] !== ed[i] || q_last[i] !== (i == 3)) begin
          errors++;
          $display("FAIL wrap_beat%0d: addr=%0d data=%h last=%b, want %0d/%h/%b",
                   i, q_addr[i], q_data[i], q_last[i], ea[i], ed[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    kick(5'd2, 5'd3);
    @(negedge clk);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 64'd2 || bus.out_addr !== 5'd2 || bus.out_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_c%0d: valid=%b data=%h addr=%0d last=%b, want 1/2/2/0",
                 c, bus.out_valid, bus.out_data, bus.out_addr, bus.out_last);
      end
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_reload: valid=%b, want 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'd3 || bus.out_addr !== 5'd3 || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: valid=%b data=%h addr=%0d last=%b, want 1/3/3/1",
               bus.out_valid, bus.out_data, bus.out_addr, bus.out_last);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: done=%b, want 1", bus.done);
    end
  endtask

  task automatic test_ignored_start_coherency;
    int dc;
    bus.out_ready = 1'b1;
    kick(5'd0, 5'd7);
    fork
      collect(40, dc);
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.first_addr = 5'd10;
        bus.last_addr  = 5'd12;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1 regs[4] = 64'hDEAD;
      end
    join
    checks++;
    if (q_addr.size() != 8 || dc != 17) begin
      errors++;
      $display("FAIL ign_count: got %0d beats done cycle %0d, want 8 and 17", q_addr.size(), dc);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_addr[i] !== 5'(i) || q_data[i] !== 64'(i) || q_last[i] !== (i == 7)) begin
          errors++;
          $display("FAIL ign_beat%0d: addr=%0d data=%h last=%b, want %0d/%0d/%b",
                   i, q_addr[i], q_data[i], q_last[i], i, i, (i == 7));
        end
      end
    end
    kick(5'd4, 5'd4);
    collect(10, dc);
    checks++;
    if (q_data.size() != 1 || q_data[0] !== 64'hDEAD || q_addr[0] !== 5'd4) begin
      errors++;
      $display("FAIL coherency_redump: beats=%0d data=%h, want 1 beat of dead at addr 4",
               q_data.size(), (q_data.size() > 0) ? q_data[0] : 64'd0);
    end
  endtask

  task automatic test_async_reset;
    int dc;
    bus.out_ready = 1'b0;
    kick(5'd8, 5'd9);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_addr !== 5'd8) begin
      errors++;
      $display("FAIL ar_pre: valid=%b addr=%0d, want 1/8", bus.out_valid, bus.out_addr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.out_data !== 64'd0 || bus.out_addr !== 5'd0 || bus.ra !== 5'd0) begin
      errors++;
      $display("FAIL ar_async: valid=%b busy=%b done=%b data=%h addr=%0d ra=%0d, want all 0",
               bus.out_valid, bus.busy, bus.done, bus.out_data, bus.out_addr, bus.ra);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_hold: done=%b valid=%b, want 0/0", bus.done, bus.out_valid);
    end
    reset = 1'b0;
    bus.out_ready = 1'b1;
    kick(5'd6, 5'd6);
    collect(10, dc);
    checks++;
    if (q_addr.size() != 1 || q_addr[0] !== 5'd6 || q_data[0] !== 64'd6 || q_last[0] !== 1'b1 || dc != 3) begin
      errors++;
      $display("FAIL ar_restart: beats=%0d done cycle %0d, want one beat 6/6/last and done cycle 3",
               q_addr.size(), dc);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 31) ? 64'd0 : 64'(i);
    bus.start      = 1'b0;
    bus.first_addr = 5'd0;
    bus.last_addr  = 5'd0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_single();
    test_full_sweep();
    test_wrap();
    test_backpressure();
    test_ignored_start_coherency();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
